fp_addsub_seq: RTL and testbench

- Parametrised, multi-cycle floating-point add/subtract unit for the lab's custom format.
- Format per operand: sign bit, unsigned EXP_W exponent, MANT_W mantissa whose MSB is the integer bit (value = mant/2^(MANT_W-1) * 2^exp).
- Successor to the combinational exponent-difference datapath: adds operand swap, serial alignment shifter, add/sub, normalisation, saturation flags and valid/ready handshakes.
- Sits between operand registers and the result writeback stage.

---
 rtl/fp_addsub_seq.sv | 168 ++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle add/subtract for the lab's sign/exponent/mantissa format.
// Operand swap, serial alignment, add/sub, serial normalisation, saturation flags.
module fp_addsub_seq #(
  parameter int MANT_W = 16,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op,
  input  logic              sgn_a,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [MANT_W-1:0] mant_a,
  input  logic              sgn_b,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [MANT_W-1:0] mant_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sgn_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              ovf,
  output logic              unf,
  output logic              busy
);

  localparam int CNT_W = $clog2(MANT_W + 1);
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t r_state, r_state_nxt;

  logic              r_sgn_l, r_sgn_s;
  logic [MANT_W-1:0] r_mant_l, r_mant_s;
  logic [CNT_W-1:0]  r_cnt;
  logic [MANT_W:0]   r_res;
  logic              r_sgn;
  logic [EXP_W-1:0]  r_e;
  logic              r_sgn_out;
  logic [EXP_W-1:0]  r_exp_out;
  logic [MANT_W-1:0] r_mant_out;
  logic              r_ovf, r_unf;

  logic              w_sgn_b_eff;
  logic              w_swap;
  logic [EXP_W-1:0]  w_d;
  logic [CNT_W-1:0]  w_cnt_init;
  logic              w_norm_shl;

  assign w_sgn_b_eff = sgn_b ^ op;
  assign w_swap      = (exp_b > exp_a);
  assign w_d         = w_swap ? (exp_b - exp_a) : (exp_a - exp_b);
  assign w_cnt_init  = (32'(w_d) >= MANT_W) ? CNT_W'(MANT_W) : CNT_W'(w_d);

  // Only a non-zero, unnormalised result above exponent 0 needs another left shift.
  assign w_norm_shl = !r_res[MANT_W] && (r_res != '0) && !r_res[MANT_W-1] && (r_e != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)      r_state_nxt = S_ALIGN;
      S_ALIGN: if (r_cnt == '0)   r_state_nxt = S_ADD;
      S_ADD:                      r_state_nxt = S_NORM;
      S_NORM:  if (!w_norm_shl)   r_state_nxt = S_DONE;
      S_DONE:  if (out_ready)     r_state_nxt = S_IDLE;
      default:                    r_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sgn_l    <= 1'b0;
      r_sgn_s    <= 1'b0;
      r_mant_l   <= '0;
      r_mant_s   <= '0;
      r_cnt      <= '0;
      r_res      <= '0;
      r_sgn      <= 1'b0;
      r_e        <= '0;
      r_sgn_out  <= 1'b0;
      r_exp_out  <= '0;
      r_mant_out <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sgn_l  <= w_swap ? w_sgn_b_eff : sgn_a;
            r_mant_l <= w_swap ? mant_b : mant_a;
            r_e      <= w_swap ? exp_b : exp_a;
            r_sgn_s  <= w_swap ? sgn_a : w_sgn_b_eff;
            r_mant_s <= w_swap ? mant_a : mant_b;
            r_cnt    <= w_cnt_init;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
          end
        end
        S_ALIGN: begin
          if (r_cnt != '0) begin
            r_mant_s <= r_mant_s >> 1;
            r_cnt    <= r_cnt - CNT_ONE;
          end
        end
        S_ADD: begin
          if (r_sgn_l == r_sgn_s) begin
            r_res <= {1'b0, r_mant_l} + {1'b0, r_mant_s};
            r_sgn <= r_sgn_l;
          end else if (r_mant_l >= r_mant_s) begin
            r_res <= {1'b0, r_mant_l - r_mant_s};
            r_sgn <= r_sgn_l;
          end else begin
            r_res <= {1'b0, r_mant_s - r_mant_l};
            r_sgn <= r_sgn_s;
          end
        end
        S_NORM: begin
          if (r_res[MANT_W]) begin
            r_sgn_out <= r_sgn;
            if (r_e == '1) begin
              r_ovf      <= 1'b1;
              r_exp_out  <= '1;
              r_mant_out <= '1;
            end else begin
              r_exp_out  <= r_e + EXP_ONE;
              r_mant_out <= r_res[MANT_W:1];
            end
          end else if (r_res == '0) begin
            r_sgn_out  <= 1'b0;
            r_exp_out  <= '0;
            r_mant_out <= '0;
          end else if (r_res[MANT_W-1]) begin
            r_sgn_out  <= r_sgn;
            r_exp_out  <= r_e;
            r_mant_out <= r_res[MANT_W-1:0];
          end else if (r_e == '0) begin
            r_unf      <= 1'b1;
            r_sgn_out  <= r_sgn;
            r_exp_out  <= r_e;
            r_mant_out <= r_res[MANT_W-1:0];
          end else begin
            r_res <= {r_res[MANT_W-1:0], 1'b0};
            r_e   <= r_e - EXP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sgn_out   = r_sgn_out;
  assign exp_out   = r_exp_out;
  assign mant_out  = r_mant_out;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed scoreboard bench for fp_addsub_seq (MANT_W=16, EXP_W=8).
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, op;
  logic        sgn_a, sgn_b;
  logic [7:0]  exp_a, exp_b;
  logic [15:0] mant_a, mant_b;
  logic        out_valid, out_ready;
  logic        sgn_out;
  logic [7:0]  exp_out;
  logic [15:0] mant_out;
  logic        ovf, unf, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sgn;
    logic [7:0]  e;
    logic [15:0] m;
    logic        ovf;
    logic        unf;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  fp_addsub_seq #(.MANT_W(16), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .sgn_a(sgn_a), .exp_a(exp_a), .mant_a(mant_a),
    .sgn_b(sgn_b), .exp_b(exp_b), .mant_b(mant_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sgn_out(sgn_out), .exp_out(exp_out), .mant_out(mant_out),
    .ovf(ovf), .unf(unf), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic sa, input logic [7:0] ea, input logic [15:0] ma,
                       input logic sb, input logic [7:0] eb, input logic [15:0] mb,
                       input logic o);
    sgn_a = sa; exp_a = ea; mant_a = ma;
    sgn_b = sb; exp_b = eb; mant_b = mb;
    op = o;
  endtask

  task automatic recover();
    rst_n = 1'b0;
    #3;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Accept one operand pair, then wait for and score the result.
  task automatic run_op(input string tag,
                        input logic sa, input logic [7:0] ea, input logic [15:0] ma,
                        input logic sb, input logic [7:0] eb, input logic [15:0] mb,
                        input logic o, input exp_t e, input logic release_out);
    int   lat;
    exp_t got;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    drive(sa, ea, ma, sb, eb, mb, o);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back(e);
    check({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sb_q.pop_front();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_lat"},   lat, got.lat);
    check({tag, "_sgn"},   sgn_out, got.sgn);
    check({tag, "_exp"},   exp_out, got.e);
    check({tag, "_mant"},  mant_out, got.m);
    check({tag, "_ovf"},   ovf, got.ovf);
    check({tag, "_unf"},   unf, got.unf);
    if (!out_valid) recover();
    else if (release_out) begin
      @(posedge clk); #1;
      check({tag, "_idle"}, in_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_outs", {sgn_out, exp_out, mant_out, ovf, unf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("eq_add",  1'b0, 8'd10,  16'h8000, 1'b0, 8'd10,  16'h8000, 1'b0,
           '{sgn:1'b0, e:8'd11,  m:16'h8000, ovf:1'b0, unf:1'b0, lat:3},  1'b1);
    run_op("align2",  1'b0, 8'd10,  16'hC000, 1'b0, 8'd8,   16'h8000, 1'b0,
           '{sgn:1'b0, e:8'd10,  m:16'hE000, ovf:1'b0, unf:1'b0, lat:5},  1'b1);
    run_op("sub_l1",  1'b0, 8'd10,  16'h8000, 1'b0, 8'd9,   16'h8000, 1'b1,
           '{sgn:1'b0, e:8'd9,   m:16'h8000, ovf:1'b0, unf:1'b0, lat:5},  1'b1);
    run_op("swap",    1'b0, 8'd5,   16'h8000, 1'b0, 8'd7,   16'h8000, 1'b1,
           '{sgn:1'b1, e:8'd6,   m:16'hC000, ovf:1'b0, unf:1'b0, lat:6},  1'b1);
    run_op("zero",    1'b1, 8'd10,  16'h8000, 1'b1, 8'd10,  16'h8000, 1'b1,
           '{sgn:1'b0, e:8'd0,   m:16'h0000, ovf:1'b0, unf:1'b0, lat:3},  1'b1);
    run_op("ovf",     1'b0, 8'd255, 16'h8000, 1'b0, 8'd255, 16'h8000, 1'b0,
           '{sgn:1'b0, e:8'hFF,  m:16'hFFFF, ovf:1'b1, unf:1'b0, lat:3},  1'b1);

    // Back-pressure: result must hold while new operands are offered and ignored.
    out_ready = 1'b0;
    run_op("hold",    1'b0, 8'd10,  16'h8000, 1'b0, 8'd10,  16'h8000, 1'b0,
           '{sgn:1'b0, e:8'd11,  m:16'h8000, ovf:1'b0, unf:1'b0, lat:3},  1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 8'd3, 16'h4000, 1'b0, 8'd2, 16'h9000, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", {sgn_out, exp_out, mant_out}, {1'b0, 8'd11, 16'h8000});
      check("hold_flags", {ovf, unf}, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_valid", out_valid, 0);
    check("hold_release_ready", in_ready, 1);

    // Asynchronous reset in the middle of a long alignment.
    @(negedge clk);
    drive(1'b0, 8'd40, 16'h8000, 1'b0, 8'd0, 16'hFFFF, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_outs", {sgn_out, exp_out, mant_out, ovf, unf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("unf",     1'b0, 8'd1,   16'h8000, 1'b0, 8'd1,   16'h7FFF, 1'b1,
           '{sgn:1'b0, e:8'd0,   m:16'h0002, ovf:1'b0, unf:1'b1, lat:4},  1'b1);
    run_op("shiftout",1'b0, 8'd40,  16'h8000, 1'b0, 8'd0,   16'hFFFF, 1'b0,
           '{sgn:1'b0, e:8'd40,  m:16'h8000, ovf:1'b0, unf:1'b0, lat:19}, 1'b1);

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
